// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: PC register, next-PC select, IMEM drive, IF/ID register with redirect squash.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap to MTVEC instead of being masked.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  PC_SOURCE,
   input  logic [31:0] JALR_TGT,
   input  logic [31:0] BRANCH_TGT,
   input  logic [31:0] JAL_TGT,
   input  logic [31:0] MTVEC,
   input  logic [31:0] MEPC,
   input  logic        PC_WRITE,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_RDEN,
   input  logic [31:0] IMEM_DOUT,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_IR,
   output logic        ID_VALID,
   output logic        FLUSH,
   output logic [31:0] FLUSH_CNT,
   output logic        MISALIGN
);

   typedef enum logic [1:0] {BOOT, RUN, REDIR} state_t;

   state_t      state, state_nx;
   logic        redirect, advance, take_word, misalign;
   logic [31:0] pc, fetch_pc, sel_tgt, next_tgt;

   always_comb begin
      sel_tgt = 32'h0;
      case (PC_SOURCE)
         4'd1:    sel_tgt = JALR_TGT;
         4'd2:    sel_tgt = BRANCH_TGT;
         4'd3:    sel_tgt = JAL_TGT;
         4'd4:    sel_tgt = MTVEC;
         4'd5:    sel_tgt = MEPC;
         default: sel_tgt = 32'h0;
      endcase
   end

   assign redirect = !RST && (PC_SOURCE >= 4'd1) && (PC_SOURCE <= 4'd5);
   assign advance  = !RST && !redirect && PC_WRITE;

`ifdef FETCH_MISALIGN_TRAP_EN
   // MTVEC itself is never re-trapped; a misaligned vector is simply masked.
   assign misalign = redirect && (PC_SOURCE != 4'd4) && (sel_tgt[1:0] != 2'b00);
   assign next_tgt = misalign ? (MTVEC & ~32'h3) : (sel_tgt & ~32'h3);
`else
   assign misalign = 1'b0;
   assign next_tgt = sel_tgt & ~32'h3;
`endif

   assign IMEM_ADDR = pc;
   assign IMEM_RDEN = RST || redirect || PC_WRITE;
   assign FLUSH     = redirect;
   assign MISALIGN  = misalign;

   always_ff @(posedge CLK) begin
      if (RST) state <= BOOT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (redirect)     state_nx = REDIR;
      else if (advance) state_nx = RUN;
   end

   // Only in RUN is the word coming back from memory on the right path.
   always_comb begin
      take_word = (state == RUN);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc        <= RESET_VEC;
         fetch_pc  <= 32'h0;
         ID_PC     <= 32'h0;
         ID_IR     <= NOP_INSTR;
         ID_VALID  <= 1'b0;
         FLUSH_CNT <= 32'h0;
      end else if (redirect) begin
         pc        <= next_tgt;
         fetch_pc  <= pc;
         ID_IR     <= NOP_INSTR;
         ID_VALID  <= 1'b0;
         FLUSH_CNT <= FLUSH_CNT + 32'd1;
      end else if (advance) begin
         pc       <= pc + 32'd4;
         fetch_pc <= pc;
         if (take_word) begin
            ID_IR    <= IMEM_DOUT;
            ID_PC    <= fetch_pc;
            ID_VALID <= 1'b1;
         end else begin
            ID_IR    <= NOP_INSTR;
            ID_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus random traffic vs an instruction-stream model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  PC_SOURCE = 4'd0;
   logic [31:0] JALR_TGT = 32'h0, BRANCH_TGT = 32'h0, JAL_TGT = 32'h0, MTVEC = 32'h0, MEPC = 32'h0;
   logic        PC_WRITE = 1'b1;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_RDEN;
   logic [31:0] IMEM_DOUT = 32'h0;
   logic [31:0] ID_PC, ID_IR, FLUSH_CNT;
   logic        ID_VALID, FLUSH, MISALIGN;

   int n_cmp = 0;
   int n_bad = 0;

   // Instruction-stream model: PC, the word in flight tagged right/wrong path, and ID contents.
   logic [31:0] m_pc = 32'h0, m_fl_addr = 32'h0, m_id_pc = 32'h0, m_id_ir = NOP, m_cnt = 32'h0;
   logic        m_fl_ok = 1'b0, m_id_vld = 1'b0, m_known = 1'b0;

   pc_fetch_ctrl dut (
      .CLK(CLK), .RST(RST), .PC_SOURCE(PC_SOURCE),
      .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT), .MTVEC(MTVEC), .MEPC(MEPC),
      .PC_WRITE(PC_WRITE), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDEN(IMEM_RDEN), .IMEM_DOUT(IMEM_DOUT),
      .ID_PC(ID_PC), .ID_IR(ID_IR), .ID_VALID(ID_VALID), .FLUSH(FLUSH), .FLUSH_CNT(FLUSH_CNT),
      .MISALIGN(MISALIGN)
   );

   always #5 CLK = ~CLK;

   // Synchronous instruction memory; word content is 32'hA0 + address.
   always @(posedge CLK) if (IMEM_RDEN) IMEM_DOUT <= 32'hA0 + IMEM_ADDR;

   // One clock: apply inputs, compare at the falling edge against the model, advance the model.
   task automatic step(input logic rst, input logic [3:0] src, input logic pcw);
      logic        redir, mis;
      logic [31:0] sel, tgt;
      RST = rst; PC_SOURCE = src; PC_WRITE = pcw;
      redir = !rst && src >= 4'd1 && src <= 4'd5;
      case (src)
         4'd1: sel = JALR_TGT;
         4'd2: sel = BRANCH_TGT;
         4'd3: sel = JAL_TGT;
         4'd4: sel = MTVEC;
         4'd5: sel = MEPC;
         default: sel = 32'h0;
      endcase
      mis = 1'b0;
      tgt = sel & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir && src != 4'd4 && sel[1:0] != 2'b00) begin
         mis = 1'b1;
         tgt = MTVEC & ~32'h3;
      end
`endif
      @(negedge CLK);
      n_cmp++; if (FLUSH !== redir) begin n_bad++; $display("FAIL flush: got %b want %b", FLUSH, redir); end
      n_cmp++; if (MISALIGN !== mis) begin n_bad++; $display("FAIL misalign: got %b want %b", MISALIGN, mis); end
      if (!rst) begin
         n_cmp++; if (IMEM_RDEN !== (redir | pcw)) begin n_bad++; $display("FAIL rden: got %b want %b", IMEM_RDEN, redir | pcw); end
      end
      if (m_known) begin
         n_cmp++; if (IMEM_ADDR !== m_pc) begin n_bad++; $display("FAIL imem_addr: got %h want %h", IMEM_ADDR, m_pc); end
         n_cmp++; if (FLUSH_CNT !== m_cnt) begin n_bad++; $display("FAIL flush_cnt: got %0d want %0d", FLUSH_CNT, m_cnt); end
         n_cmp++; if (ID_VALID !== m_id_vld) begin n_bad++; $display("FAIL id_valid: got %b want %b", ID_VALID, m_id_vld); end
         n_cmp++; if (ID_IR !== m_id_ir) begin n_bad++; $display("FAIL id_ir: got %h want %h", ID_IR, m_id_ir); end
         if (m_id_vld) begin
            n_cmp++; if (ID_PC !== m_id_pc) begin n_bad++; $display("FAIL id_pc: got %h want %h", ID_PC, m_id_pc); end
         end
      end
      if (rst) begin
         m_pc = 32'h0; m_fl_ok = 1'b0; m_id_pc = 32'h0; m_id_ir = NOP; m_id_vld = 1'b0; m_cnt = 32'h0;
         m_known = 1'b1;
      end else if (redir) begin
         m_pc = tgt; m_fl_ok = 1'b0; m_id_ir = NOP; m_id_vld = 1'b0; m_cnt = m_cnt + 32'd1;
      end else if (pcw) begin
         if (m_fl_ok) begin
            m_id_pc = m_fl_addr; m_id_ir = 32'hA0 + m_fl_addr; m_id_vld = 1'b1;
         end else begin
            m_id_ir = NOP; m_id_vld = 1'b0;
         end
         m_fl_addr = m_pc; m_fl_ok = 1'b1; m_pc = m_pc + 32'd4;
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      step(1'b1, 4'd2, 1'b1);
      step(1'b1, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", IMEM_ADDR); end
      n_cmp++; if (ID_PC !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc: got %h want 0", ID_PC); end
      n_cmp++; if (ID_IR !== NOP) begin n_bad++; $display("FAIL reset_id_ir: got %h want %h", ID_IR, NOP); end
      n_cmp++; if (ID_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid: got %b want 0", ID_VALID); end
      n_cmp++; if (FLUSH_CNT !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", FLUSH_CNT); end
   endtask

   task automatic test_sequential();
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h4) begin n_bad++; $display("FAIL seq_addr1: got %h want 4", IMEM_ADDR); end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h8) begin n_bad++; $display("FAIL seq_addr2: got %h want 8", IMEM_ADDR); end
      n_cmp++; if (ID_IR !== 32'hA0 || ID_PC !== 32'h0 || ID_VALID !== 1'b1) begin
         n_bad++; $display("FAIL seq_first_id: got ir=%h pc=%h v=%b want ir=a0 pc=0 v=1", ID_IR, ID_PC, ID_VALID);
      end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'hC) begin n_bad++; $display("FAIL seq_addr3: got %h want c", IMEM_ADDR); end
   endtask

   task automatic test_branch();
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h10) begin n_bad++; $display("FAIL br_pre_addr: got %h want 10", IMEM_ADDR); end
      BRANCH_TGT = 32'h100;
      step(1'b0, 4'd2, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h100 || ID_VALID !== 1'b0 || FLUSH_CNT !== 32'd1) begin
         n_bad++; $display("FAIL br_n1: got addr=%h v=%b cnt=%0d want 100/0/1", IMEM_ADDR, ID_VALID, FLUSH_CNT);
      end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_VALID !== 1'b0) begin n_bad++; $display("FAIL br_n2_valid: got %b want 0", ID_VALID); end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_PC !== 32'h100 || ID_IR !== 32'h1A0 || ID_VALID !== 1'b1) begin
         n_bad++; $display("FAIL br_n3_id: got pc=%h ir=%h v=%b want 100/1a0/1", ID_PC, ID_IR, ID_VALID);
      end
   endtask

   task automatic test_stall();
      JAL_TGT = 32'h14;
      step(1'b0, 4'd3, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'd0, 1'b0);
         n_cmp++; if (IMEM_ADDR !== 32'h20 || ID_PC !== 32'h18 || ID_IR !== 32'hB8) begin
            n_bad++; $display("FAIL stall_hold%0d: got addr=%h pc=%h ir=%h want 20/18/b8", i, IMEM_ADDR, ID_PC, ID_IR);
         end
      end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h24 || ID_PC !== 32'h1C || ID_VALID !== 1'b1) begin
         n_bad++; $display("FAIL stall_resume1: got addr=%h pc=%h v=%b want 24/1c/1", IMEM_ADDR, ID_PC, ID_VALID);
      end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_PC !== 32'h20 || ID_IR !== 32'hC0) begin
         n_bad++; $display("FAIL stall_resume2: got pc=%h ir=%h want 20/c0", ID_PC, ID_IR);
      end
   endtask

   task automatic test_redirect_in_stall();
      MTVEC = 32'h200;
      step(1'b0, 4'd4, 1'b0);
      n_cmp++; if (IMEM_ADDR !== 32'h200 || FLUSH_CNT !== 32'd3) begin
         n_bad++; $display("FAIL stall_redir: got addr=%h cnt=%0d want 200/3", IMEM_ADDR, FLUSH_CNT);
      end
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);
   endtask

   task automatic test_back_to_back();
      JAL_TGT = 32'h40; MEPC = 32'h80;
      step(1'b0, 4'd3, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h40) begin n_bad++; $display("FAIL b2b_addr1: got %h want 40", IMEM_ADDR); end
      step(1'b0, 4'd5, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h80 || FLUSH_CNT !== 32'd5) begin
         n_bad++; $display("FAIL b2b_addr2: got addr=%h cnt=%0d want 80/5", IMEM_ADDR, FLUSH_CNT);
      end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_VALID !== 1'b0) begin n_bad++; $display("FAIL b2b_squash: got %b want 0", ID_VALID); end
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_VALID !== 1'b1 || ID_PC !== 32'h80) begin
         n_bad++; $display("FAIL b2b_first: got v=%b pc=%h want 1/80", ID_VALID, ID_PC);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] want;
`ifdef FETCH_MISALIGN_TRAP_EN
      want = 32'h300;
`else
      want = 32'h100;
`endif
      JALR_TGT = 32'h103; MTVEC = 32'h300;
      step(1'b0, 4'd1, 1'b1);
      n_cmp++; if (IMEM_ADDR !== want) begin n_bad++; $display("FAIL misalign_addr: got %h want %h", IMEM_ADDR, want); end
      MTVEC = 32'h203;
      step(1'b0, 4'd4, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h200) begin n_bad++; $display("FAIL mtvec_mask: got %h want 200", IMEM_ADDR); end
      JAL_TGT = 32'hFFFF_FFF8;
      step(1'b0, 4'd3, 1'b1);
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL pc_wrap: got %h want 0", IMEM_ADDR); end
   endtask

   task automatic test_reset_mid();
      BRANCH_TGT = 32'h500;
      step(1'b0, 4'd2, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      n_cmp++; if (IMEM_ADDR !== 32'h0 || FLUSH_CNT !== 32'h0 || ID_VALID !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid: got addr=%h cnt=%0d v=%b want 0/0/0", IMEM_ADDR, FLUSH_CNT, ID_VALID);
      end
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);
      n_cmp++; if (ID_IR !== 32'hA0 || ID_VALID !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid_restart: got ir=%h v=%b want a0/1", ID_IR, ID_VALID);
      end
   endtask

   task automatic test_random();
      logic [3:0] src;
      for (int i = 0; i < 400; i++) begin
         JALR_TGT   = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         BRANCH_TGT = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         JAL_TGT    = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         MTVEC      = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         MEPC       = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         src = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
         step(($urandom_range(0, 49) == 0), src, ($urandom_range(0, 3) != 0));
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_redirect_in_stall();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-side consumer of the branch condition generator's 4-bit PC-source select. It holds the program counter, chooses the next PC from the candidate targets, and drives the synchronous instruction memory. It also owns the IF/ID pipeline register and generates the FLUSH pulse and wrong-path squashing on every redirect, including interrupt entry and mret.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value injected into ID when squashed (addi x0,x0,0).
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; synchronous, active-high.
- PC_SOURCE  in  4  select from branch condition generator: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC (interrupt), 5 MEPC (mret), 6–15 treated as 0.
- JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC  in  32 each  candidate targets, valid in the cycle PC_SOURCE selects them.
- PC_WRITE  in  1  0 = stall request from hazard unit.
- IMEM_ADDR  out  32  fetch address, equal to the PC register.
- IMEM_RDEN  out  1  memory read enable.
- IMEM_DOUT  in  32  instruction word; valid the cycle after an enabled read; held by the memory while IMEM_RDEN=0.
- ID_PC  out  32  PC of the instruction in ID.
- ID_IR  out  32  instruction in ID.
- ID_VALID  out  1  ID holds a real, right-path instruction.
- FLUSH  out  1  combinational; high in every redirect cycle; tells the hazard unit to bubble ID/EX.
- FLUSH_CNT  out  32  count of redirects, wraps at 2^32.
- MISALIGN  out  1  see Configuration.

## Operation
- Redirect: a cycle with PC_SOURCE in 1–5 and RST=0.
- Next PC in a redirect cycle is the selected target.
- Next PC otherwise is PC+4, modulo 2^32. PC 32'hFFFF_FFFC wraps to 0.
- Every PC load forces bits [1:0] to 2'b00, except where the MISALIGN path applies.
- Priority: RST > redirect > stall > normal advance.
- The FSM tracks whether the word returning from memory is usable.
  - BOOT: entered on reset. No word is in flight. ID loads NOP_INSTR with ID_VALID=0. Go to RUN next cycle unless a redirect occurs (then REDIR).
  - RUN: the returning word is right-path. On advance, ID_IR<=IMEM_DOUT, ID_PC<=the previously fetched PC, ID_VALID<=1. A redirect goes to REDIR.
  - REDIR: the returning word belongs to the wrong-path address fetched during the redirect cycle. Discard it: ID loads NOP_INSTR with ID_VALID=0. Go to RUN, or stay in REDIR on a back-to-back redirect.
- Redirect cycle actions:
  - PC<=target.
  - ID squashed to NOP_INSTR with ID_VALID=0.
  - FLUSH=1.
  - FLUSH_CNT increments.
  - IMEM_RDEN=1.
- Stall cycle (PC_WRITE=0, no redirect):
  - PC, fetched-PC register, ID_PC, ID_IR, ID_VALID and FSM state are all held.
  - IMEM_RDEN=0, so the returning word is preserved.
- Redirect during stall: the redirect wins and the stall is ignored that cycle.

## Timing
- Reset values: PC=RESET_VEC, IMEM_ADDR=RESET_VEC, IMEM_RDEN=1 in the cycle after reset, ID_PC=0, ID_IR=NOP_INSTR, ID_VALID=0, FLUSH=0, FLUSH_CNT=0, MISALIGN=0, FSM=BOOT.
- While RST=1: FLUSH=0 and MISALIGN=0, regardless of PC_SOURCE.
- Fetch-to-ID latency: an instruction at address A presented on IMEM_ADDR in cycle n appears on ID_IR/ID_PC in cycle n+2, with no stalls or redirects.
- Redirect penalty: in redirect cycle n, the target appears on IMEM_ADDR at n+1 and its instruction reaches ID at n+3. ID_VALID=0 in cycles n+1 and n+2.
- Each stall cycle adds exactly one cycle to latency. No instruction is lost or duplicated.
- A synchronous reset asserted mid-redirect or mid-stall overrides all pending state in the same edge.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect target with [1:0]≠0 is not loaded.
  - PC<=MTVEC with [1:0] cleared instead.
  - MISALIGN pulses high for that one cycle (combinational, same cycle as FLUSH).
  - FLUSH_CNT increments once.
  - A misaligned MTVEC itself is masked, not re-trapped.
- FETCH_MISALIGN_TRAP_EN not defined:
  - Target bits [1:0] are silently masked.
  - MISALIGN is tied to 0.

## Test plan
- Reset, then run 4 cycles with PC_SOURCE=0 and IMEM returning 32'hA0+addr → IMEM_ADDR 0,4,8,C. ID_IR first valid (32'hA0) two cycles after reset release, with ID_PC=0.
- PC_SOURCE=2 with BRANCH_TGT=32'h100 while IMEM_ADDR=32'h10 → FLUSH=1 for one cycle. Next IMEM_ADDR=32'h100. ID_VALID=0 for two cycles. ID_PC=32'h100 three cycles after the redirect. FLUSH_CNT=1.
- PC_WRITE=0 for 3 cycles at IMEM_ADDR=32'h20 → IMEM_ADDR, ID_PC, ID_IR frozen and IMEM_RDEN=0. Sequence resumes 32'h24 with no skipped or duplicated ID_PC.
- PC_WRITE=0 together with PC_SOURCE=4 and MTVEC=32'h200 → redirect wins: IMEM_ADDR=32'h200 next cycle, FLUSH=1.
- Back-to-back PC_SOURCE=3 (JAL_TGT=32'h40) then 5 (MEPC=32'h80) → FSM stays in REDIR. IMEM_ADDR goes 32'h40 then 32'h80. FLUSH_CNT+=2. Only the instruction at 32'h80 reaches ID valid.
- JALR_TGT=32'h103 with PC_SOURCE=1 → without the macro, IMEM_ADDR=32'h100. With FETCH_MISALIGN_TRAP_EN and MTVEC=32'h300, IMEM_ADDR=32'h300 and MISALIGN=1 for one cycle.
